// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request, register-file write and hazard lookup bundle for the write arbiter
interface regfile_write_arbiter_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int FIFO_DEPTH     = 4
);
  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      prim_valid;
  logic                      prim_ready;
  logic [AW-1:0]             prim_address;
  logic [REGISTER_WIDTH-1:0] prim_data;

  logic                      sec_valid;
  logic                      sec_ready;
  logic [AW-1:0]             sec_address;
  logic [REGISTER_WIDTH-1:0] sec_data;

  logic                      write_enable;
  logic [AW-1:0]             write_address;
  logic [REGISTER_WIDTH-1:0] write_data;

  logic [CW-1:0]             pending_count;
  logic [AW-1:0]             lookup_address;
  logic                      lookup_pending;

  modport master (
    output prim_valid, prim_address, prim_data,
    output sec_valid, sec_address, sec_data,
    output lookup_address,
    input  prim_ready, sec_ready,
    input  write_enable, write_address, write_data,
    input  pending_count, lookup_pending
  );

  modport slave (
    input  prim_valid, prim_address, prim_data,
    input  sec_valid, sec_address, sec_data,
    input  lookup_address,
    output prim_ready, sec_ready,
    output write_enable, write_address, write_data,
    output pending_count, lookup_pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares one register-file write port between writeback and a queued long-latency path
module regfile_write_arbiter #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]             q_addr [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     q_valid;
  logic [FIFO_DEPTH-1:0]     q_valid_next;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [SW-1:0]             starve_cnt;

  logic prim_use;
  logic q_empty;
  logic forced;
  logic pop;
  logic push;
  logic grant_prim;
  logic sec_ready_int;
  logic lookup_hit;

  always_comb begin
    prim_use      = bus.prim_valid && (bus.prim_address != '0);
    q_empty       = (count == '0);
    forced        = !q_empty && prim_use && (starve_cnt == SW'(STARVE_LIMIT));
    pop           = rst && !q_empty && (!prim_use || forced);
    grant_prim    = rst && prim_use && !pop;
    // Full-ness comes from the registered count only; a same-cycle pop never frees a slot.
    sec_ready_int = rst && (count < CW'(FIFO_DEPTH));
    push          = sec_ready_int && bus.sec_valid && (bus.sec_address != '0);
  end

  always_comb begin
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    if (pop) begin
      bus.write_enable  = 1'b1;
      bus.write_address = q_addr[rd_ptr];
      bus.write_data    = q_data[rd_ptr];
    end else if (grant_prim) begin
      bus.write_enable  = 1'b1;
      bus.write_address = bus.prim_address;
      bus.write_data    = bus.prim_data;
    end
  end

  always_comb begin
    bus.prim_ready    = rst && !forced;
    bus.sec_ready     = sec_ready_int;
    bus.pending_count = rst ? count : '0;
  end

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_valid[i] && (q_addr[i] == bus.lookup_address)) begin
        lookup_hit = 1'b1;
      end
    end
    bus.lookup_pending = rst && lookup_hit && (bus.lookup_address != '0);
  end

  // Push and pop slots never coincide: pop needs a non-empty queue, push a non-full one.
  always_comb begin
    q_valid_next = q_valid;
    if (pop) begin
      q_valid_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      q_valid_next[wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.sec_address;
      q_data[wr_ptr] <= bus.sec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_valid    <= '0;
      starve_cnt <= '0;
    end else begin
      q_valid <= q_valid_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (pop || q_empty) begin
        starve_cnt <= '0;
      end else if (grant_prim && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - table vectors plus queue scoreboard for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;
  localparam int FIFO_DEPTH     = 4;
  localparam int STARVE_LIMIT   = 4;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic [4:0]  la;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_prdy;
    logic        e_srdy;
    logic [2:0]  e_cnt;
    logic        e_lp;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   starve = 0;
  ent_t sq[$];
  vec_t tbl[17];
  bit   saw_full;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(
    .REGISTER_WIDTH(REGISTER_WIDTH),
    .REGISTER_DEPTH(REGISTER_DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  regfile_write_arbiter #(
    .REGISTER_WIDTH(REGISTER_WIDTH),
    .REGISTER_DEPTH(REGISTER_DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic vec_t mk(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                              input logic sv, input logic [4:0] sa, input logic [31:0] sd, input logic [4:0] la,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic prdy, input logic srdy, input logic [2:0] cnt, input logic lp);
    vec_t v;
    v.rst = r; v.pv = pv; v.pa = pa; v.pd = pd; v.sv = sv; v.sa = sa; v.sd = sd; v.la = la;
    v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_prdy = prdy; v.e_srdy = srdy; v.e_cnt = cnt; v.e_lp = lp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle: drive, compare at negedge against the queue model, then advance the model at posedge.
  task automatic step(input vec_t v, input bit use_tbl);
    logic        e_we, e_prdy, e_srdy, e_lp;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    int          e_cnt;
    bit          puse, empty, forced, pop, push;
    rst              = v.rst;
    bus.prim_valid   = v.pv;
    bus.prim_address = v.pa;
    bus.prim_data    = v.pd;
    bus.sec_valid    = v.sv;
    bus.sec_address  = v.sa;
    bus.sec_data     = v.sd;
    bus.lookup_address = v.la;
    @(negedge clk);
    puse   = v.pv && (v.pa != 0);
    empty  = (sq.size() == 0);
    forced = !empty && puse && (starve == STARVE_LIMIT);
    pop    = v.rst && !empty && (!puse || forced);
    e_we = 0; e_wa = 0; e_wd = 0; e_prdy = 0; e_srdy = 0; e_lp = 0; e_cnt = 0;
    if (v.rst) begin
      e_prdy = !forced;
      e_srdy = (sq.size() < FIFO_DEPTH);
      e_cnt  = sq.size();
      if (pop) begin
        e_we = 1; e_wa = sq[0].a; e_wd = sq[0].d;
      end else if (puse) begin
        e_we = 1; e_wa = v.pa; e_wd = v.pd;
      end
      if (v.la != 0) begin
        foreach (sq[i]) if (sq[i].a == v.la) e_lp = 1;
      end
    end
    push = v.rst && v.sv && e_srdy && (v.sa != 0);
    chk("write_enable", bus.write_enable, e_we);
    chk("write_address", bus.write_address, e_wa);
    chk("write_data", bus.write_data, e_wd);
    chk("prim_ready", bus.prim_ready, e_prdy);
    chk("sec_ready", bus.sec_ready, e_srdy);
    chk("pending_count", bus.pending_count, e_cnt);
    chk("lookup_pending", bus.lookup_pending, e_lp);
    if (use_tbl) begin
      chk("tbl_write_enable", bus.write_enable, v.e_we);
      chk("tbl_write_address", bus.write_address, v.e_wa);
      chk("tbl_write_data", bus.write_data, v.e_wd);
      chk("tbl_prim_ready", bus.prim_ready, v.e_prdy);
      chk("tbl_sec_ready", bus.sec_ready, v.e_srdy);
      chk("tbl_pending_count", bus.pending_count, v.e_cnt);
      chk("tbl_lookup_pending", bus.lookup_pending, v.e_lp);
    end
    @(posedge clk);
    if (!v.rst) begin
      sq.delete();
      starve = 0;
    end else begin
      if (pop || empty) starve = 0;
      else if (puse && starve < STARVE_LIMIT) starve++;
      if (pop) void'(sq.pop_front());
      if (push) sq.push_back('{v.sa, v.sd});
    end
    cyc++;
    #1;
  endtask

  initial begin
    vec_t v;
    bus.prim_valid = 0; bus.prim_address = 0; bus.prim_data = 0;
    bus.sec_valid = 0; bus.sec_address = 0; bus.sec_data = 0; bus.lookup_address = 0;

    tbl[0]  = mk(0, 1, 5, 32'h1,        1, 3,  32'h2,  3,  0, 0,  32'h0,        0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,  0,  1, 5,  32'hDEADBEEF, 1, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 32'h0,        1, 7,  32'h12, 7,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,  7,  1, 7,  32'h12,       1, 1, 1, 1);
    tbl[4]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,  7,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 32'h0,        1, 0,  32'h55, 0,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,  0,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 32'h0,        1, 9,  32'h99, 9,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[8]  = mk(1, 1, 0, 32'h77,       0, 0,  32'h0,  9,  1, 9,  32'h99,       1, 1, 1, 1);
    tbl[9]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,  9,  0, 0,  32'h0,        1, 1, 0, 0);
    tbl[10] = mk(1, 1, 1, 32'h101,      1, 10, 32'hA0, 10, 1, 1,  32'h101,      1, 1, 0, 0);
    tbl[11] = mk(1, 1, 2, 32'h102,      0, 0,  32'h0,  10, 1, 2,  32'h102,      1, 1, 1, 1);
    tbl[12] = mk(1, 1, 3, 32'h103,      0, 0,  32'h0,  10, 1, 3,  32'h103,      1, 1, 1, 1);
    tbl[13] = mk(1, 1, 4, 32'h104,      0, 0,  32'h0,  10, 1, 4,  32'h104,      1, 1, 1, 1);
    tbl[14] = mk(1, 1, 5, 32'h105,      0, 0,  32'h0,  10, 1, 5,  32'h105,      1, 1, 1, 1);
    tbl[15] = mk(1, 1, 6, 32'h106,      0, 0,  32'h0,  10, 1, 10, 32'hA0,       0, 1, 1, 1);
    tbl[16] = mk(1, 1, 6, 32'h106,      0, 0,  32'h0,  10, 1, 6,  32'h106,      1, 1, 0, 0);

    for (int i = 0; i < 17; i++) step(tbl[i], 1'b1);

    // Full queue under continuous primary traffic; the drain after the fourth grant reopens a slot.
    saw_full = 0;
    for (int i = 0; i < 9; i++) begin
      v = mk(1, 1, 5'(20 + i), 32'(32'h200 + i), 1, 5'(11 + i), 32'(32'h300 + i), 5'(11 + i),
             0, 0, 0, 0, 0, 0, 0);
      step(v, 1'b0);
      if (bus.pending_count == 3'd4) begin
        saw_full = 1;
        chk("full_sec_ready", bus.sec_ready, 1'b0);
      end
    end
    chk("full_reached", saw_full, 1'b1);
    for (int i = 0; i < 6; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Reset with three entries queued: nothing of them may be written afterwards.
    for (int i = 0; i < 3; i++) step(mk(1, 1, 5'(1 + i), 32'(i), 1, 5'(12 + i), 32'(32'h400 + i), 12, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("rst_pre_count", bus.pending_count, 3'd3);
    step(mk(0, 1, 4, 32'h5, 1, 15, 32'h6, 12, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("rst_post_count", bus.pending_count, 3'd0);
    step(mk(1, 1, 8, 32'hCAFE, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
             0, 0, 0, 0, 0, 0, 0);
      step(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
